// File: rtl/axi_slave_package.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_package
// Description : Shared types and helpers for the AXI slave bridge: the
//               requester-recorder entry layout, AXI RESP encodings, PCIe
//               completion status encodings and the status-to-RESP mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_slave_package;

    // Requester recorder geometry
    localparam int REQUESTER_RECORDER_ADDR_WIDTH = 5;
    localparam int RECORDER_ID_WIDTH             = 8;
    localparam int RECORDER_BC_WIDTH             = 13;
    localparam int REQUESTER_RECORDER_WIDTH      = 2 + RECORDER_ID_WIDTH + RECORDER_BC_WIDTH;

    // One outstanding request, packed MSB to LSB
    typedef struct packed {
        logic                         valid;
        logic                         is_write;
        logic [RECORDER_ID_WIDTH-1:0] axi_id;
        logic [RECORDER_BC_WIDTH-1:0] rem_bytes;
    } recorder_entry_t;

    // AXI RESP encodings
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // PCIe completion status encodings
    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
    localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
    localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

    // Unsupported Request means nothing answers at that address, so it maps
    // to DECERR; every other failure is reported as a slave error.
    function automatic logic [1:0] cpl_status_to_resp(input logic [2:0] status);
        logic [1:0] resp;
        case (status)
            CPL_STATUS_SC: resp = AXI_RESP_OKAY;
            CPL_STATUS_UR: resp = AXI_RESP_DECERR;
            default:       resp = AXI_RESP_SLVERR;
        endcase
        return resp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/completion_tag_matcher.sv
`default_nettype none
// ============================================================================
// Module      : completion_tag_matcher
// Description : Matches parsed PCIe completion headers against the requester
//               recorder (indexed by tag), updates or retires the entry and
//               emits one AXI response descriptor per completion. Completions
//               to non-outstanding tags are flagged and counted.
// Ports       : clk/ARESET      - clock, async active-high reset
//               cpl_*           - completion header in (valid/ready)
//               resp_rd_*       - recorder combinational read port
//               resp_wr_*       - recorder write port
//               rsp_*           - AXI response descriptor out (valid/ready)
//               unexp_cpl/cnt   - unmatched completion pulse / saturating count
// Revision    : 1.0 - initial release
// ============================================================================
module completion_tag_matcher
    import axi_slave_package::*;
#(
    parameter int TAG_WIDTH = REQUESTER_RECORDER_ADDR_WIDTH,
    parameter int ID_WIDTH  = RECORDER_ID_WIDTH,
    parameter int BC_WIDTH  = RECORDER_BC_WIDTH
) (
    input  logic                                clk,
    input  logic                                ARESET,
    input  logic                                cpl_valid,
    output logic                                cpl_ready,
    input  logic [TAG_WIDTH-1:0]                cpl_tag,
    input  logic [2:0]                          cpl_status,
    input  logic [11:0]                         cpl_byte_count,
    input  logic [9:0]                          cpl_length_dw,
    output logic [TAG_WIDTH-1:0]                resp_rd_addr,
    input  logic [REQUESTER_RECORDER_WIDTH-1:0] resp_rd_data,
    output logic                                resp_wr_en,
    output logic [TAG_WIDTH-1:0]                resp_wr_addr,
    output logic [REQUESTER_RECORDER_WIDTH-1:0] resp_wr_data,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [ID_WIDTH-1:0]                 rsp_id,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_last,
    output logic                                rsp_is_write,
    output logic                                unexp_cpl,
    output logic [7:0]                          unexp_cnt
);

    localparam int c_EW = REQUESTER_RECORDER_WIDTH;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    logic [TAG_WIDTH-1:0] r_tag;
    logic [2:0]           r_status;
    logic [BC_WIDTH-1:0]  r_bc;
    logic [BC_WIDTH:0]    r_len_bytes;
    logic [c_EW-1:0]      r_entry;
    logic [7:0]           r_unexp_cnt;
    logic [ID_WIDTH-1:0]  r_rsp_id;
    logic [1:0]           r_rsp_resp;
    logic                 r_rsp_last;
    logic                 r_rsp_is_write;

    logic [BC_WIDTH-1:0]  w_bc_in;
    logic [BC_WIDTH:0]    w_len_in;
    logic                 w_last;
    logic [BC_WIDTH-1:0]  w_rem;
    logic                 w_hit;
    logic                 w_unused;

    // Byte Count of zero encodes a full 4 KiB.
    assign w_bc_in  = (cpl_byte_count == 12'd0) ? BC_WIDTH'(4096) : BC_WIDTH'(cpl_byte_count);
    assign w_len_in = (BC_WIDTH+1)'({cpl_length_dw, 2'b00});

    assign w_hit = resp_rd_data[c_EW-1];

    // An error ends the request, writes complete in one shot, and a read is
    // done once this completion carries all the bytes still outstanding.
    assign w_last = (r_status != CPL_STATUS_SC) || r_entry[c_EW-2] ||
                    ({1'b0, r_bc} <= r_len_bytes);
    // Only used when not last, so byte count exceeds payload and cannot wrap.
    assign w_rem  = r_bc - r_len_bytes[BC_WIDTH-1:0];

    // The stored remaining-byte field is superseded by the header byte count.
    assign w_unused = ^r_entry[BC_WIDTH-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        cpl_ready    = 1'b0;
        resp_wr_en   = 1'b0;
        resp_wr_data = '0;
        rsp_valid    = 1'b0;
        unexp_cpl    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                cpl_ready = ~ARESET;
                if (cpl_valid) begin
                    w_next_state = c_ST_LOOKUP;
                end
            end
            c_ST_LOOKUP: begin
                if (w_hit) begin
                    w_next_state = c_ST_WRITE;
                end else begin
                    unexp_cpl    = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_WRITE: begin
                resp_wr_en   = 1'b1;
                // All-zeros retires the entry; otherwise keep valid/is_write/id.
                resp_wr_data = w_last ? '0 : {r_entry[c_EW-1:BC_WIDTH], w_rem};
                w_next_state = c_ST_RESP;
            end
            c_ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_tag          <= '0;
            r_status       <= '0;
            r_bc           <= '0;
            r_len_bytes    <= '0;
            r_entry        <= '0;
            r_unexp_cnt    <= '0;
            r_rsp_id       <= '0;
            r_rsp_resp     <= '0;
            r_rsp_last     <= 1'b0;
            r_rsp_is_write <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cpl_valid) begin
                        r_tag       <= cpl_tag;
                        r_status    <= cpl_status;
                        r_bc        <= w_bc_in;
                        r_len_bytes <= w_len_in;
                    end
                end
                c_ST_LOOKUP: begin
                    r_entry <= resp_rd_data;
                    if (!w_hit && (r_unexp_cnt != 8'hFF)) begin
                        r_unexp_cnt <= r_unexp_cnt + 8'd1;
                    end
                end
                c_ST_WRITE: begin
                    r_rsp_id       <= r_entry[c_EW-3 -: ID_WIDTH];
                    r_rsp_resp     <= cpl_status_to_resp(r_status);
                    r_rsp_last     <= w_last;
                    r_rsp_is_write <= r_entry[c_EW-2];
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_rd_addr = r_tag;
    assign resp_wr_addr = r_tag;
    assign rsp_id       = r_rsp_id;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_last     = r_rsp_last;
    assign rsp_is_write = r_rsp_is_write;
    assign unexp_cnt    = r_unexp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_completion_tag_matcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_completion_tag_matcher
// Description : Self-checking bench for completion_tag_matcher. Stimulus
//               pushes expected recorder writes and response descriptors into
//               queues; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_completion_tag_matcher;
    import axi_slave_package::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        ARESET;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [4:0]  cpl_tag;
    logic [2:0]  cpl_status;
    logic [11:0] cpl_byte_count;
    logic [9:0]  cpl_length_dw;
    logic [4:0]  resp_rd_addr;
    logic [22:0] resp_rd_data;
    logic        resp_wr_en;
    logic [4:0]  resp_wr_addr;
    logic [22:0] resp_wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic        rsp_last;
    logic        rsp_is_write;
    logic        unexp_cpl;
    logic [7:0]  unexp_cnt;

    completion_tag_matcher dut (
        .clk            (clk),
        .ARESET         (ARESET),
        .cpl_valid      (cpl_valid),
        .cpl_ready      (cpl_ready),
        .cpl_tag        (cpl_tag),
        .cpl_status     (cpl_status),
        .cpl_byte_count (cpl_byte_count),
        .cpl_length_dw  (cpl_length_dw),
        .resp_rd_addr   (resp_rd_addr),
        .resp_rd_data   (resp_rd_data),
        .resp_wr_en     (resp_wr_en),
        .resp_wr_addr   (resp_wr_addr),
        .resp_wr_data   (resp_wr_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_resp       (rsp_resp),
        .rsp_last       (rsp_last),
        .rsp_is_write   (rsp_is_write),
        .unexp_cpl      (unexp_cpl),
        .unexp_cnt      (unexp_cnt)
    );

    // Recorder model: combinational read, preload port for the bench
    logic [22:0] mem [32];
    logic        tb_clr;
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [22:0] pre_data;

    assign resp_rd_data = mem[resp_rd_addr];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (resp_wr_en) begin
            mem[resp_wr_addr] <= resp_wr_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] q_rsp [$];   // {id, resp, last, is_write}
    logic [27:0] q_wr  [$];   // {addr, data}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [22:0] ent(input logic v, input logic w,
                                        input logic [7:0] id, input logic [12:0] rem);
        return {v, w, id, rem};
    endfunction

    function automatic logic [11:0] rx(input logic [7:0] id, input logic [1:0] resp,
                                       input logic last, input logic w);
        return {id, resp, last, w};
    endfunction

    // Monitor: compare on every descriptor handshake and every recorder write
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (q_rsp.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got id=%h resp=%b with none expected", rsp_id, rsp_resp);
            end else begin
                chk("rsp", {52'd0, rsp_id, rsp_resp, rsp_last, rsp_is_write}, {52'd0, q_rsp.pop_front()});
            end
        end
        if (resp_wr_en) begin
            if (q_wr.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: got addr=%h data=%h with none expected", resp_wr_addr, resp_wr_data);
            end else begin
                chk("recorder_write", {36'd0, resp_wr_addr, resp_wr_data}, {36'd0, q_wr.pop_front()});
            end
        end
    end

    // All stimulus tasks start and end at posedge + #1
    task automatic preload(input logic [4:0] a, input logic [22:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic send(input logic [4:0] tag, input logic [2:0] st,
                        input logic [11:0] bc, input logic [9:0] len);
        logic r;
        logic ok;
        ok             = 1'b0;
        cpl_tag        = tag;
        cpl_status     = st;
        cpl_byte_count = bc;
        cpl_length_dw  = len;
        cpl_valid      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = cpl_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        #1 cpl_valid = 1'b0;
        if (!ok) chk("cpl_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpl_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        ARESET         = 1'b1;
        tb_clr         = 1'b1;
        pre_en         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        cpl_valid      = 1'b0;
        cpl_tag        = '0;
        cpl_status     = '0;
        cpl_byte_count = '0;
        cpl_length_dw  = '0;
        rsp_ready      = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_cpl_ready", cpl_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_en", resp_wr_en, 0);
        chk("rst_unexp_cnt", unexp_cnt, 0);
        @(posedge clk); #1 tb_clr = 1'b0;
        @(posedge clk); #1 ARESET = 1'b0;
        @(negedge clk);
        chk("post_rst_cpl_ready", cpl_ready, 1);
        @(posedge clk); #1;

        // ---------------- single-shot read with latency ----------------
        preload(3, ent(1, 0, 8'h2A, 13'd64));
        q_wr.push_back({5'd3, 23'd0});
        q_rsp.push_back(rx(8'h2A, 2'b00, 1, 0));
        send(3, CPL_STATUS_SC, 12'd64, 10'd16);
        @(negedge clk);
        chk("c1_wr_en", resp_wr_en, 0);
        chk("c1_cpl_ready", cpl_ready, 0);
        chk("c1_unexp", unexp_cpl, 0);
        @(negedge clk);
        chk("c2_wr_en", resp_wr_en, 1);
        chk("c2_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("c3_rsp_valid", rsp_valid, 1);
        wait_idle();
        chk("tag3_retired", mem[3], 0);

        // ---------------- split read ----------------
        preload(7, ent(1, 0, 8'h11, 13'd128));
        q_wr.push_back({5'd7, ent(1, 0, 8'h11, 13'd96)});
        q_rsp.push_back(rx(8'h11, 2'b00, 0, 0));
        send(7, CPL_STATUS_SC, 12'd128, 10'd8);
        wait_idle();
        chk("tag7_rem96", mem[7], ent(1, 0, 8'h11, 13'd96));
        q_wr.push_back({5'd7, 23'd0});
        q_rsp.push_back(rx(8'h11, 2'b00, 1, 0));
        send(7, CPL_STATUS_SC, 12'd96, 10'd24);
        wait_idle();
        chk("tag7_retired", mem[7], 0);

        // ---------------- byte count 0 encodes 4096 ----------------
        preload(4, ent(1, 0, 8'h44, 13'd4096));
        q_wr.push_back({5'd4, ent(1, 0, 8'h44, 13'd2048)});
        q_rsp.push_back(rx(8'h44, 2'b00, 0, 0));
        send(4, CPL_STATUS_SC, 12'd0, 10'd512);
        wait_idle();
        q_wr.push_back({5'd4, 23'd0});
        q_rsp.push_back(rx(8'h44, 2'b00, 1, 0));
        send(4, CPL_STATUS_SC, 12'd2048, 10'd512);
        wait_idle();

        // ---------------- write request is always final ----------------
        preload(2, ent(1, 1, 8'h77, 13'd0));
        q_wr.push_back({5'd2, 23'd0});
        q_rsp.push_back(rx(8'h77, 2'b00, 1, 1));
        send(2, CPL_STATUS_SC, 12'd4, 10'd0);
        wait_idle();

        // ---------------- error statuses ----------------
        preload(5, ent(1, 0, 8'h05, 13'd200));
        q_wr.push_back({5'd5, 23'd0});
        q_rsp.push_back(rx(8'h05, 2'b11, 1, 0));
        send(5, CPL_STATUS_UR, 12'd200, 10'd4);
        wait_idle();
        chk("tag5_retired_ur", mem[5], 0);
        preload(5, ent(1, 0, 8'h05, 13'd200));
        q_wr.push_back({5'd5, 23'd0});
        q_rsp.push_back(rx(8'h05, 2'b10, 1, 0));
        send(5, CPL_STATUS_CA, 12'd200, 10'd4);
        wait_idle();
        preload(5, ent(1, 0, 8'h06, 13'd200));
        q_wr.push_back({5'd5, 23'd0});
        q_rsp.push_back(rx(8'h06, 2'b10, 1, 0));
        send(5, CPL_STATUS_CRS, 12'd200, 10'd4);
        wait_idle();

        // ---------------- unmatched tag ----------------
        send(9, CPL_STATUS_SC, 12'd4, 10'd1);
        @(negedge clk);
        chk("unexp_pulse", unexp_cpl, 1);
        chk("unexp_no_wr", resp_wr_en, 0);
        @(negedge clk);
        chk("unexp_pulse_end", unexp_cpl, 0);
        chk("unexp_cnt_1", unexp_cnt, 1);
        chk("unexp_ready_c2", cpl_ready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 299; i++) send(9, CPL_STATUS_SC, 12'd4, 10'd1);
        wait_idle();
        chk("unexp_cnt_sat", unexp_cnt, 255);

        // ---------------- back-pressure ----------------
        preload(10, ent(1, 0, 8'h3C, 13'd8));
        preload(11, ent(1, 0, 8'h3D, 13'd8));
        rsp_ready = 1'b0;
        q_wr.push_back({5'd10, 23'd0});
        q_rsp.push_back(rx(8'h3C, 2'b00, 1, 0));
        q_wr.push_back({5'd11, 23'd0});
        q_rsp.push_back(rx(8'h3D, 2'b00, 1, 0));
        send(10, CPL_STATUS_SC, 12'd8, 10'd2);
        cpl_tag        = 5'd11;
        cpl_status     = CPL_STATUS_SC;
        cpl_byte_count = 12'd8;
        cpl_length_dw  = 10'd2;
        cpl_valid      = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_cpl_ready", cpl_ready, 0);
            chk("stall_rsp", {51'd0, rsp_valid, rsp_id, rsp_resp, rsp_last, rsp_is_write},
                {51'd0, 1'b1, rx(8'h3C, 2'b00, 1, 0)});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_ready", cpl_ready, 1);
        @(posedge clk); #1 cpl_valid = 1'b0;
        @(negedge clk);
        chk("second_hdr_taken", cpl_ready, 0);
        wait_idle();

        // ---------------- reset during WRITE ----------------
        preload(12, ent(1, 0, 8'h12, 13'd8));
        send(12, CPL_STATUS_SC, 12'd8, 10'd2);
        @(posedge clk);
        #1 ARESET = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", resp_wr_en, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_unexp_cnt", unexp_cnt, 0);
        @(posedge clk); #1 ARESET = 1'b0;
        @(negedge clk);
        chk("abort_idle", cpl_ready, 1);
        chk("abort_entry_kept", mem[12], ent(1, 0, 8'h12, 13'd8));
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 0);

        chk("rsp_queue_empty", q_rsp.size(), 0);
        chk("wr_queue_empty", q_wr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
